// File: rtl/superpixel_scan_mapper_pkg.sv
// Shared defaults and width helpers for the superpixel scan mapper.
// Widths are derived from counts, so a 1-value range still gets a 1-bit field.
package superpixel_scan_mapper_pkg;

    localparam int DEF_PIXEL_X_MAX = 640;
    localparam int DEF_PIXEL_Y_MAX = 480;
    localparam int DEF_SCALE_X     = 10;
    localparam int DEF_SCALE_Y     = 10;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/superpixel_scan_mapper_axis.sv
// One scan axis: pixel, sub-offset, superpixel index and the superpixel's clamped pixel bounds.
// cur_* is the position of the element consumed this cycle; clr forces it to 0 before advancing.
module superpixel_scan_mapper_axis
    import superpixel_scan_mapper_pkg::*;
#(
    parameter int LEN   = 640,
    parameter int SCALE = 10,
    localparam int PX_W = clog2_min1(LEN),
    localparam int SC_W = clog2_min1(SCALE),
    localparam int SP_W = clog2_min1(ceil_div(LEN, SCALE))
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            adv,
    output logic [PX_W-1:0] cur_px,
    output logic [SC_W-1:0] cur_sub,
    output logic [SP_W-1:0] cur_sp,
    output logic [PX_W-1:0] cur_tl,
    output logic [PX_W-1:0] cur_br,
    output logic            wrap
);

    localparam int AW = PX_W + 1;
    localparam logic [PX_W-1:0] LAST_PX  = PX_W'(LEN - 1);
    localparam logic [SC_W-1:0] LAST_SUB = SC_W'(SCALE - 1);
    localparam logic [PX_W-1:0] BR0      = PX_W'(((SCALE < LEN) ? SCALE : LEN) - 1);

    logic [PX_W-1:0] px_q, px_d, tl_q, tl_d, br_q, br_d;
    logic [SC_W-1:0] sub_q, sub_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [AW-1:0]   tl_next, br_next;

    always_comb begin
        cur_px  = clr ? '0  : px_q;
        cur_sub = clr ? '0  : sub_q;
        cur_sp  = clr ? '0  : sp_q;
        cur_tl  = clr ? '0  : tl_q;
        cur_br  = clr ? BR0 : br_q;
        wrap    = adv && (cur_px == LAST_PX);
        // One extra bit so the unclamped right edge can be compared against LEN-1.
        tl_next = {1'b0, cur_tl} + AW'(SCALE);
        br_next = tl_next + AW'(SCALE - 1);
        px_d    = cur_px;
        sub_d   = cur_sub;
        sp_d    = cur_sp;
        tl_d    = cur_tl;
        br_d    = cur_br;
        if (adv) begin
            if (cur_px == LAST_PX) begin
                px_d  = '0;
                sub_d = '0;
                sp_d  = '0;
                tl_d  = '0;
                br_d  = BR0;
            end else begin
                px_d = cur_px + PX_W'(1);
                if (cur_sub == LAST_SUB) begin
                    sub_d = '0;
                    sp_d  = cur_sp + SP_W'(1);
                    tl_d  = tl_next[PX_W-1:0];
                    br_d  = (br_next > AW'(LEN - 1)) ? LAST_PX : br_next[PX_W-1:0];
                end else begin
                    sub_d = cur_sub + SC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            px_q  <= '0;
            sub_q <= '0;
            sp_q  <= '0;
            tl_q  <= '0;
            br_q  <= BR0;
        end else begin
            px_q  <= px_d;
            sub_q <= sub_d;
            sp_q  <= sp_d;
            tl_q  <= tl_d;
            br_q  <= br_d;
        end
    end

endmodule

// File: rtl/superpixel_scan_mapper.sv
// Streaming pixel-to-superpixel mapper: X axis advances per accepted pixel, Y axis per X wrap.
// Handshake: a pixel is consumed on any cycle with i_de=1 (no backpressure); o_valid marks the cycle after.
module superpixel_scan_mapper
    import superpixel_scan_mapper_pkg::*;
#(
    parameter int PIXEL_X_MAX = DEF_PIXEL_X_MAX,
    parameter int PIXEL_Y_MAX = DEF_PIXEL_Y_MAX,
    parameter int SCALE_X     = DEF_SCALE_X,
    parameter int SCALE_Y     = DEF_SCALE_Y,
    localparam int SPIXEL_X_MAX = ceil_div(PIXEL_X_MAX, SCALE_X),
    localparam int SPIXEL_Y_MAX = ceil_div(PIXEL_Y_MAX, SCALE_Y),
    localparam int SPX_W = clog2_min1(SPIXEL_X_MAX),
    localparam int SPY_W = clog2_min1(SPIXEL_Y_MAX),
    localparam int SCX_W = clog2_min1(SCALE_X),
    localparam int SCY_W = clog2_min1(SCALE_Y),
    localparam int PX_W  = clog2_min1(PIXEL_X_MAX),
    localparam int PY_W  = clog2_min1(PIXEL_Y_MAX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame_start,
    input  logic             i_de,
    output logic             o_valid,
    output logic [SPX_W-1:0] o_sp_x,
    output logic [SPY_W-1:0] o_sp_y,
    output logic [SCX_W-1:0] o_sub_x,
    output logic [SCY_W-1:0] o_sub_y,
    output logic [PX_W-1:0]  o_tlx,
    output logic [PY_W-1:0]  o_tly,
    output logic [PX_W-1:0]  o_brx,
    output logic [PY_W-1:0]  o_bry,
    output logic             o_sp_first,
    output logic             o_sp_last,
    output logic             o_grid,
    output logic             o_overrun
);

    logic accept;
    logic [PX_W-1:0]  x_px, x_tl, x_br;
    logic [SCX_W-1:0] x_sub;
    logic [SPX_W-1:0] x_sp;
    logic             x_wrap;
    logic [PY_W-1:0]  y_px, y_tl, y_br;
    logic [SCY_W-1:0] y_sub;
    logic [SPY_W-1:0] y_sp;
    logic             y_wrap;

    logic             valid_q, valid_d, first_q, first_d, last_q, last_d, grid_q, grid_d;
    logic             overrun_q, overrun_d, frame_done_q, frame_done_d, rst_hold_q, rst_hold_d;
    logic [SPX_W-1:0] sp_x_q, sp_x_d;
    logic [SPY_W-1:0] sp_y_q, sp_y_d;
    logic [SCX_W-1:0] sub_x_q, sub_x_d;
    logic [SCY_W-1:0] sub_y_q, sub_y_d;
    logic [PX_W-1:0]  tlx_q, tlx_d, brx_q, brx_d;
    logic [PY_W-1:0]  tly_q, tly_d, bry_q, bry_d;

    superpixel_scan_mapper_axis #(.LEN(PIXEL_X_MAX), .SCALE(SCALE_X)) u_axis_x (
        .clk(clk), .rst(rst), .clr(i_frame_start), .adv(accept),
        .cur_px(x_px), .cur_sub(x_sub), .cur_sp(x_sp), .cur_tl(x_tl), .cur_br(x_br), .wrap(x_wrap)
    );

    superpixel_scan_mapper_axis #(.LEN(PIXEL_Y_MAX), .SCALE(SCALE_Y)) u_axis_y (
        .clk(clk), .rst(rst), .clr(i_frame_start), .adv(x_wrap),
        .cur_px(y_px), .cur_sub(y_sub), .cur_sp(y_sp), .cur_tl(y_tl), .cur_br(y_br), .wrap(y_wrap)
    );

    always_comb begin
        // The cycle right after reset is blocked too, so no pixel shows up one cycle out of reset.
        accept     = i_de && !rst_hold_q;
        rst_hold_d = 1'b0;
        valid_d    = accept;
        sp_x_d     = sp_x_q;
        sp_y_d     = sp_y_q;
        sub_x_d    = sub_x_q;
        sub_y_d    = sub_y_q;
        tlx_d      = tlx_q;
        tly_d      = tly_q;
        brx_d      = brx_q;
        bry_d      = bry_q;
        first_d    = first_q;
        last_d     = last_q;
        grid_d     = grid_q;
        if (accept) begin
            sp_x_d  = x_sp;
            sp_y_d  = y_sp;
            sub_x_d = x_sub;
            sub_y_d = y_sub;
            tlx_d   = x_tl;
            tly_d   = y_tl;
            brx_d   = x_br;
            bry_d   = y_br;
            first_d = (x_sub == '0) && (y_sub == '0);
            last_d  = (x_px == x_br) && (y_px == y_br);
            grid_d  = (x_sub == '0) || (y_sub == '0) || (x_px == x_br) || (y_px == y_br);
        end
        // A pixel arriving after the last line of a frame, with no new frame_start, is an overrun.
        frame_done_d = (!i_frame_start && frame_done_q) || y_wrap;
        overrun_d    = !i_frame_start && (overrun_q || (accept && frame_done_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            sp_x_q       <= '0;
            sp_y_q       <= '0;
            sub_x_q      <= '0;
            sub_y_q      <= '0;
            tlx_q        <= '0;
            tly_q        <= '0;
            brx_q        <= '0;
            bry_q        <= '0;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            grid_q       <= 1'b0;
            overrun_q    <= 1'b0;
            frame_done_q <= 1'b0;
            rst_hold_q   <= 1'b1;
        end else begin
            valid_q      <= valid_d;
            sp_x_q       <= sp_x_d;
            sp_y_q       <= sp_y_d;
            sub_x_q      <= sub_x_d;
            sub_y_q      <= sub_y_d;
            tlx_q        <= tlx_d;
            tly_q        <= tly_d;
            brx_q        <= brx_d;
            bry_q        <= bry_d;
            first_q      <= first_d;
            last_q       <= last_d;
            grid_q       <= grid_d;
            overrun_q    <= overrun_d;
            frame_done_q <= frame_done_d;
            rst_hold_q   <= rst_hold_d;
        end
    end

    assign o_valid    = valid_q;
    assign o_sp_x     = sp_x_q;
    assign o_sp_y     = sp_y_q;
    assign o_sub_x    = sub_x_q;
    assign o_sub_y    = sub_y_q;
    assign o_tlx      = tlx_q;
    assign o_tly      = tly_q;
    assign o_brx      = brx_q;
    assign o_bry      = bry_q;
    assign o_sp_first = first_q;
    assign o_sp_last  = last_q;
    assign o_grid     = grid_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_superpixel_scan_mapper.sv
// Bench for superpixel_scan_mapper: a default 640x480/10x10 instance and a 40x480/12x7 instance
// driven with continuous, gapped, frame_start and reset sequences against hand-computed tables.
module tb_superpixel_scan_mapper;

    typedef struct packed {
        logic valid;
        logic ovr;
        int   sp_x;
        int   sp_y;
        int   sub_x;
        int   sub_y;
        int   tlx;
        int   tly;
        int   brx;
        int   bry;
        logic first;
        logic last;
        logic grid;
    } pix_t;

    typedef struct {
        int   x;
        int   y;
        pix_t e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic       a_rst = 1'b1, a_fs = 1'b0, a_de = 1'b0;
    logic       a_valid, a_first, a_last, a_grid, a_ovr;
    logic [5:0] a_sp_x, a_sp_y;
    logic [3:0] a_sub_x, a_sub_y;
    logic [9:0] a_tlx, a_brx;
    logic [8:0] a_tly, a_bry;

    superpixel_scan_mapper u_dut_a (
        .clk(clk), .rst(a_rst), .i_frame_start(a_fs), .i_de(a_de),
        .o_valid(a_valid), .o_sp_x(a_sp_x), .o_sp_y(a_sp_y), .o_sub_x(a_sub_x), .o_sub_y(a_sub_y),
        .o_tlx(a_tlx), .o_tly(a_tly), .o_brx(a_brx), .o_bry(a_bry),
        .o_sp_first(a_first), .o_sp_last(a_last), .o_grid(a_grid), .o_overrun(a_ovr)
    );

    // Instance B: 40 wide, partial superpixels on both axes
    logic       b_rst = 1'b1, b_fs = 1'b0, b_de = 1'b0;
    logic       b_valid, b_first, b_last, b_grid, b_ovr;
    logic [1:0] b_sp_x;
    logic [6:0] b_sp_y;
    logic [3:0] b_sub_x;
    logic [2:0] b_sub_y;
    logic [5:0] b_tlx, b_brx;
    logic [8:0] b_tly, b_bry;

    superpixel_scan_mapper #(.PIXEL_X_MAX(40), .PIXEL_Y_MAX(480), .SCALE_X(12), .SCALE_Y(7)) u_dut_b (
        .clk(clk), .rst(b_rst), .i_frame_start(b_fs), .i_de(b_de),
        .o_valid(b_valid), .o_sp_x(b_sp_x), .o_sp_y(b_sp_y), .o_sub_x(b_sub_x), .o_sub_y(b_sub_y),
        .o_tlx(b_tlx), .o_tly(b_tly), .o_brx(b_brx), .o_bry(b_bry),
        .o_sp_first(b_first), .o_sp_last(b_last), .o_grid(b_grid), .o_overrun(b_ovr)
    );

    // ---------------- model and checking helpers ----------------
    function automatic pix_t mk(int spx, int spy, int subx, int suby, int tlx, int tly,
                                int brx, int bry, logic f, logic l, logic g);
        pix_t p;
        p.valid = 1'b1; p.ovr = 1'b0;
        p.sp_x = spx; p.sp_y = spy; p.sub_x = subx; p.sub_y = suby;
        p.tlx = tlx; p.tly = tly; p.brx = brx; p.bry = bry;
        p.first = f; p.last = l; p.grid = g;
        return p;
    endfunction

    function automatic pix_t model(int x, int y, int lx, int ly, int sx, int sy, logic ovr);
        pix_t p;
        p.valid = 1'b1;
        p.ovr   = ovr;
        p.sp_x  = x / sx;
        p.sp_y  = y / sy;
        p.sub_x = x % sx;
        p.sub_y = y % sy;
        p.tlx   = p.sp_x * sx;
        p.tly   = p.sp_y * sy;
        p.brx   = (p.tlx + sx - 1 > lx - 1) ? lx - 1 : p.tlx + sx - 1;
        p.bry   = (p.tly + sy - 1 > ly - 1) ? ly - 1 : p.tly + sy - 1;
        p.first = (p.sub_x == 0) && (p.sub_y == 0);
        p.last  = (x == p.brx) && (y == p.bry);
        p.grid  = (p.sub_x == 0) || (p.sub_y == 0) || (x == p.brx) || (y == p.bry);
        return p;
    endfunction

    function automatic pix_t cap_a();
        pix_t p;
        p.valid = a_valid; p.ovr = a_ovr;
        p.sp_x = int'(a_sp_x); p.sp_y = int'(a_sp_y);
        p.sub_x = int'(a_sub_x); p.sub_y = int'(a_sub_y);
        p.tlx = int'(a_tlx); p.tly = int'(a_tly); p.brx = int'(a_brx); p.bry = int'(a_bry);
        p.first = a_first; p.last = a_last; p.grid = a_grid;
        return p;
    endfunction

    function automatic pix_t cap_b();
        pix_t p;
        p.valid = b_valid; p.ovr = b_ovr;
        p.sp_x = int'(b_sp_x); p.sp_y = int'(b_sp_y);
        p.sub_x = int'(b_sub_x); p.sub_y = int'(b_sub_y);
        p.tlx = int'(b_tlx); p.tly = int'(b_tly); p.brx = int'(b_brx); p.bry = int'(b_bry);
        p.first = b_first; p.last = b_last; p.grid = b_grid;
        return p;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_pix(input string name, input int x, input int y, input pix_t act, input pix_t exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s px=(%0d,%0d) actual v%0d o%0d sp(%0d,%0d) sub(%0d,%0d) tl(%0d,%0d) br(%0d,%0d) f%0d l%0d g%0d expected v%0d o%0d sp(%0d,%0d) sub(%0d,%0d) tl(%0d,%0d) br(%0d,%0d) f%0d l%0d g%0d",
                     name, x, y, act.valid, act.ovr, act.sp_x, act.sp_y, act.sub_x, act.sub_y,
                     act.tlx, act.tly, act.brx, act.bry, act.first, act.last, act.grid,
                     exp.valid, exp.ovr, exp.sp_x, exp.sp_y, exp.sub_x, exp.sub_y,
                     exp.tlx, exp.tly, exp.brx, exp.bry, exp.first, exp.last, exp.grid);
        end
    endtask

    task automatic check_fields(input string tag, input pix_t act, input pix_t exp);
        check({tag, ".valid"}, int'(act.valid), int'(exp.valid));
        check({tag, ".overrun"}, int'(act.ovr), int'(exp.ovr));
        check({tag, ".sp_x"}, act.sp_x, exp.sp_x);
        check({tag, ".sp_y"}, act.sp_y, exp.sp_y);
        check({tag, ".sub_x"}, act.sub_x, exp.sub_x);
        check({tag, ".sub_y"}, act.sub_y, exp.sub_y);
        check({tag, ".tlx"}, act.tlx, exp.tlx);
        check({tag, ".tly"}, act.tly, exp.tly);
        check({tag, ".brx"}, act.brx, exp.brx);
        check({tag, ".bry"}, act.bry, exp.bry);
        check({tag, ".first"}, int'(act.first), int'(exp.first));
        check({tag, ".last"}, int'(act.last), int'(exp.last));
        check({tag, ".grid"}, int'(act.grid), int'(exp.grid));
    endtask

    // ---------------- drivers for instance A ----------------
    int   ax = 0, ay = 0;
    logic a_done = 1'b0;

    task automatic a_cycle(input logic fs, input logic de, input logic r);
        @(negedge clk);
        a_fs = fs; a_de = de; a_rst = r;
        @(posedge clk);
        #1;
        a_fs = 1'b0; a_de = 1'b0; a_rst = 1'b0;
    endtask

    task automatic a_push(input logic fs, output pix_t act);
        pix_t exp;
        if (fs) begin
            ax = 0; ay = 0; a_done = 1'b0;
        end
        exp = model(ax, ay, 640, 480, 10, 10, 1'b0);
        a_cycle(fs, 1'b1, 1'b0);
        act = cap_a();
        check_pix("a_stream", ax, ay, act, exp);
        ax++;
        if (ax == 640) begin
            ax = 0; ay++;
            if (ay == 480) begin ay = 0; a_done = 1'b1; end
        end
    endtask

    task automatic a_idle();
        a_cycle(1'b0, 1'b0, 1'b0);
        check("a_gap_valid", int'(a_valid), 0);
    endtask

    // Line 2 is driven with i_de toggling every other cycle.
    task automatic a_run_to(input int x, input int y);
        pix_t act;
        int   guard = 0;
        while (!(ax == x && ay == y) && guard < 400000) begin
            if (ay == 2) a_idle();
            a_push(1'b0, act);
            guard++;
        end
        check("a_run_to_reached", int'(ax == x && ay == y), 1);
    endtask

    // ---------------- drivers for instance B ----------------
    int   bx = 0, by = 0;
    logic b_done = 1'b0;

    task automatic b_cycle(input logic fs, input logic de, input logic r);
        @(negedge clk);
        b_fs = fs; b_de = de; b_rst = r;
        @(posedge clk);
        #1;
        b_fs = 1'b0; b_de = 1'b0; b_rst = 1'b0;
    endtask

    task automatic b_push(output pix_t act);
        pix_t exp;
        exp = model(bx, by, 40, 480, 12, 7, b_done);
        b_cycle(1'b0, 1'b1, 1'b0);
        act = cap_b();
        check_pix("b_stream", bx, by, act, exp);
        bx++;
        if (bx == 40) begin
            bx = 0; by++;
            if (by == 480) begin by = 0; b_done = 1'b1; end
        end
    endtask

    task automatic b_run_to(input int x, input int y);
        pix_t act;
        int   guard = 0;
        while (!(bx == x && by == y) && guard < 400000) begin
            b_push(act);
            guard++;
        end
        check("b_run_to_reached", int'(bx == x && by == y), 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    vec_t va[7];
    vec_t vb[5];

    initial begin
        pix_t act;
        pix_t zero_p;
        pix_t e;

        va[0] = '{x: 0,   y: 0,  e: mk(0, 0, 0, 0, 0, 0, 9, 9, 1'b1, 1'b0, 1'b1)};
        va[1] = '{x: 9,   y: 0,  e: mk(0, 0, 9, 0, 0, 0, 9, 9, 1'b0, 1'b0, 1'b1)};
        va[2] = '{x: 639, y: 0,  e: mk(63, 0, 9, 0, 630, 0, 639, 9, 1'b0, 1'b0, 1'b1)};
        va[3] = '{x: 15,  y: 1,  e: mk(1, 0, 5, 1, 10, 0, 19, 9, 1'b0, 1'b0, 1'b0)};
        va[4] = '{x: 19,  y: 9,  e: mk(1, 0, 9, 9, 10, 0, 19, 9, 1'b0, 1'b1, 1'b1)};
        va[5] = '{x: 20,  y: 10, e: mk(2, 1, 0, 0, 20, 10, 29, 19, 1'b1, 1'b0, 1'b1)};
        va[6] = '{x: 327, y: 34, e: mk(32, 3, 7, 4, 320, 30, 329, 39, 1'b0, 1'b0, 1'b0)};

        vb[0] = '{x: 39, y: 0,   e: mk(3, 0, 3, 0, 36, 0, 39, 6, 1'b0, 1'b0, 1'b1)};
        vb[1] = '{x: 35, y: 6,   e: mk(2, 0, 11, 6, 24, 0, 35, 6, 1'b0, 1'b1, 1'b1)};
        vb[2] = '{x: 13, y: 10,  e: mk(1, 1, 1, 3, 12, 7, 23, 13, 1'b0, 1'b0, 1'b0)};
        vb[3] = '{x: 36, y: 476, e: mk(3, 68, 0, 0, 36, 476, 39, 479, 1'b1, 1'b0, 1'b1)};
        vb[4] = '{x: 39, y: 479, e: mk(3, 68, 3, 3, 36, 476, 39, 479, 1'b0, 1'b1, 1'b1)};

        zero_p = '0;

        // Instance A: reset state, then frame_start on an idle cycle
        a_cycle(1'b0, 1'b0, 1'b1);
        a_cycle(1'b0, 1'b0, 1'b1);
        check_fields("a_reset", cap_a(), zero_p);
        a_cycle(1'b1, 1'b0, 1'b0);
        check("a_fs_idle_valid", int'(a_valid), 0);

        for (int i = 0; i < 7; i++) begin
            a_run_to(va[i].x, va[i].y);
            if (ay == 2) a_idle();
            a_push(1'b0, act);
            check_fields($sformatf("a_vec%0d", i), act, va[i].e);
        end

        // frame_start coincident with a pixel at (200,35)
        a_run_to(200, 35);
        a_push(1'b1, act);
        check_fields("a_fs_coincident", act, mk(0, 0, 0, 0, 0, 0, 9, 9, 1'b1, 1'b0, 1'b1));
        a_push(1'b0, act);
        check("a_after_fs.sub_x", act.sub_x, 1);

        // reset mid-line at (317,1) with i_de held high
        a_run_to(317, 1);
        a_cycle(1'b0, 1'b1, 1'b1);
        check_fields("a_midline_reset", cap_a(), zero_p);
        a_cycle(1'b0, 1'b1, 1'b0);
        check("a_post_reset_valid", int'(a_valid), 0);
        ax = 0; ay = 0; a_done = 1'b0;
        a_push(1'b0, act);
        check_fields("a_after_reset", act, mk(0, 0, 0, 0, 0, 0, 9, 9, 1'b1, 1'b0, 1'b1));

        // Instance B: clamped right/bottom superpixels, then overrun
        b_cycle(1'b0, 1'b0, 1'b1);
        b_cycle(1'b0, 1'b0, 1'b1);
        check_fields("b_reset", cap_b(), zero_p);
        b_cycle(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            b_run_to(vb[i].x, vb[i].y);
            b_push(act);
            check_fields($sformatf("b_vec%0d", i), act, vb[i].e);
        end

        b_push(act);
        e = mk(0, 0, 0, 0, 0, 0, 11, 6, 1'b1, 1'b0, 1'b1);
        e.ovr = 1'b1;
        check_fields("b_overrun_line480", act, e);
        for (int i = 0; i < 3; i++) b_push(act);
        check("b_overrun_sticky", int'(act.ovr), 1);

        b_cycle(1'b1, 1'b0, 1'b0);
        bx = 0; by = 0; b_done = 1'b0;
        check("b_fs_clears_overrun", int'(b_ovr), 0);
        check("b_fs_idle_valid", int'(b_valid), 0);
        b_push(act);
        check_fields("b_new_frame", act, mk(0, 0, 0, 0, 0, 0, 11, 6, 1'b1, 1'b0, 1'b1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
